dm_subword: RTL and testbench

Parametrised, byte-addressed data memory for the multi-cycle CPU datapath, behind a req/ack handshake with a configurable number of wait states. Supports byte, halfword and word loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw) with little-endian byte order, sign/zero extension on loads, and error reporting for illegal accesses. Sits between the datapath's memory stage and the MEM-stage control FSM, which stalls on `busy`.

---
 rtl/dm_subword_if.sv | 26 ++
 rtl/dm_subword.sv | 185 ++++++++++++++++++
 tb/tb_dm_subword.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_subword_if.sv
// dm_subword_if: req/ack bus between the MEM stage and dm_subword.
// master = datapath side, slave = memory side.
interface dm_subword_if #(
    parameter int ADDR_W = 14
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       din;
    logic              ack;
    logic [31:0]       dout;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, size, sext, din,
        input  ack, dout, busy, err
    );

    modport slave (
        input  req, we, addr, size, sext, din,
        output ack, dout, busy, err
    );
endinterface

// File: rtl/dm_subword.sv
// dm_subword: byte-addressed data memory, sub-word access, wait states.
// Build macro DM_MISALIGN_TRAP_EN: misaligned half/word raise err.
module dm_subword #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_BYTES = 12288,
    parameter int WAIT_CYCLES = 1
) (
    input logic         clk,
    input logic         rst_n,
    dm_subword_if.slave bus
);

`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    logic              we_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       din_q;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              c_we;
    logic              c_sext;
    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic [31:0]       c_din;

    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [2:0]        nbytes;
    logic              mis;
    logic              oor;
    logic              ill;
    logic              go;
    logic [31:0]       ld;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Access under evaluation: live bus when accepting, latched after
    always_comb begin
        if (state == IDLE) begin
            c_we   = bus.we;
            c_sext = bus.sext;
            c_addr = bus.addr;
            c_size = bus.size;
            c_din  = bus.din;
        end else begin
            c_we   = we_q;
            c_sext = sext_q;
            c_addr = addr_q;
            c_size = size_q;
            c_din  = din_q;
        end
    end

    // Aligned byte addresses and legality of the access
    always_comb begin
        nbytes = 3'd1;
        mis    = 1'b0;
        a0     = c_addr;
        case (c_size)
            2'b01: begin
                nbytes = 3'd2;
                mis    = c_addr[0];
                a0[0]  = 1'b0;
            end
            2'b10: begin
                nbytes   = 3'd4;
                mis      = |c_addr[1:0];
                a0[1:0]  = 2'b00;
            end
            default: begin
                nbytes = 3'd1;
            end
        endcase
        oor = (32'(c_addr) + 32'(nbytes))
              > 32'(DEPTH_BYTES);
        ill = (c_size == 2'b11) || oor
              || (TRAP && mis);
        a1  = a0 + ADDR_W'(1);
        a2  = a0 + ADDR_W'(2);
        a3  = a0 + ADDR_W'(3);
    end

    // Little-endian load with sign/zero extension
    always_comb begin
        ld = '0;
        case (c_size)
            2'b00: ld = {{24{c_sext & mem[a0][7]}},
                         mem[a0]};
            2'b01: ld = {{16{c_sext & mem[a1][7]}},
                         mem[a1], mem[a0]};
            2'b10: ld = {mem[a3], mem[a2],
                         mem[a1], mem[a0]};
            default: ld = '0;
        endcase
    end

    // Edge that enters RESP; reset low blocks any commit
    assign go = rst_n &&
        ((state == IDLE && bus.req && WAIT_CYCLES == 0) ||
         (state == WAIT && cnt == 4'd1));

    // Memory port: commit store / sample load on entry to RESP
    always_ff @(posedge clk) begin
        if (go) begin
            err_q   <= ill;
            rdata_q <= (ill || c_we) ? 32'd0 : ld;
            if (!ill && c_we) begin
                mem[a0] <= c_din[7:0];
                if (c_size != 2'b00)
                    mem[a1] <= c_din[15:8];
                if (c_size == 2'b10) begin
                    mem[a2] <= c_din[23:16];
                    mem[a3] <= c_din[31:24];
                end
            end
        end
    end

    // Control FSM with registered ack/busy/dout/err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            din_q    <= '0;
            bus.ack  <= 1'b0;
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
            bus.dout <= '0;
        end else begin
            bus.ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.busy <= bus.req;
                    if (bus.req) begin
                        we_q   <= bus.we;
                        sext_q <= bus.sext;
                        addr_q <= bus.addr;
                        size_q <= bus.size;
                        din_q  <= bus.din;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= (WAIT_CYCLES == 0)
                                  ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    bus.ack  <= 1'b1;
                    bus.dout <= rdata_q;
                    bus.err  <= err_q;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_subword.sv
// tb_dm_subword: directed checks of dm_subword with WAIT_CYCLES=3.
// Expected values are hand-computed little-endian results.
module tb_dm_subword;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    dm_subword_if #(.ADDR_W(14)) bus ();

    dm_subword #(
        .ADDR_W(14),
        .DEPTH_BYTES(12288),
        .WAIT_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, got, exp);
        end
    endtask

    task automatic acc(input logic w,
                       input logic [13:0] a,
                       input logic [1:0] s,
                       input logic x,
                       input logic [31:0] d,
                       output logic [31:0] q,
                       output logic e,
                       output int lat);
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.addr = a;
        bus.size = s;
        bus.sext = x;
        bus.din  = d;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 0;
        while (!bus.ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q = bus.dout;
        e = bus.err;
    endtask

    logic [31:0] q;
    logic        e;
    int          lat;
    int          nb;
    int          na;
    int          ack1;
    int          ack2;

    initial begin
        checks   = 0;
        fails    = 0;
        rst_n    = 1'b0;
        bus.req  = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.size = '0;
        bus.sext = 1'b0;
        bus.din  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        rst_n = 1'b1;

        acc(1, 14'h10, 2'b10, 0, 32'h11223344, q, e, lat);
        chk("sw_err", 32'(e), 32'd0);
        chk("sw_dout", q, 32'd0);
        chk("sw_lat", 32'(lat), 32'd4);
        acc(0, 14'h10, 2'b10, 0, 0, q, e, lat);
        chk("lw", q, 32'h11223344);
        chk("lw_lat", 32'(lat), 32'd4);
        acc(0, 14'h10, 2'b00, 0, 0, q, e, lat);
        chk("lbu10", q, 32'h00000044);
        acc(0, 14'h13, 2'b00, 0, 0, q, e, lat);
        chk("lbu13", q, 32'h00000011);
        acc(0, 14'h11, 2'b00, 1, 0, q, e, lat);
        chk("lb11", q, 32'h00000033);

        acc(1, 14'h30, 2'b00, 0, 32'hFFFF_FF80, q, e, lat);
        acc(0, 14'h30, 2'b00, 1, 0, q, e, lat);
        chk("lb80", q, 32'hFFFFFF80);
        acc(0, 14'h30, 2'b00, 0, 0, q, e, lat);
        chk("lbu80", q, 32'h00000080);

        acc(1, 14'h20, 2'b10, 0, 32'hA5A5A5A5, q, e, lat);
        acc(1, 14'h20, 2'b01, 0, 32'h1234BEEF, q, e, lat);
        chk("sh_err", 32'(e), 32'd0);
        acc(0, 14'h20, 2'b01, 1, 0, q, e, lat);
        chk("lh", q, 32'hFFFFBEEF);
        acc(0, 14'h20, 2'b01, 0, 0, q, e, lat);
        chk("lhu", q, 32'h0000BEEF);
        acc(0, 14'h20, 2'b10, 0, 0, q, e, lat);
        chk("sh_neigh", q, 32'hA5A5BEEF);
        acc(0, 14'h22, 2'b01, 1, 0, q, e, lat);
        chk("lh22", q, 32'hFFFFA5A5);

        acc(1, 14'h20, 2'b10, 0, 32'h01020304, q, e, lat);
        acc(1, 14'h22, 2'b10, 0, 32'hCAFEF00D, q, e, lat);
`ifdef DM_MISALIGN_TRAP_EN
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_dout", q, 32'd0);
        acc(0, 14'h20, 2'b10, 0, 0, q, e, lat);
        chk("mis_mem", q, 32'h01020304);
        acc(0, 14'h21, 2'b01, 0, 0, q, e, lat);
        chk("mis_lh_err", 32'(e), 32'd1);
`else
        chk("mis_err", 32'(e), 32'd0);
        acc(0, 14'h20, 2'b10, 0, 0, q, e, lat);
        chk("mis_mem", q, 32'hCAFEF00D);
        acc(0, 14'h21, 2'b01, 0, 0, q, e, lat);
        chk("mis_lh", q, 32'h0000F00D);
`endif

        acc(1, 14'h40, 2'b11, 0, 32'hDEADBEEF, q, e, lat);
        chk("sz11_st", 32'(e), 32'd1);
        acc(0, 14'h40, 2'b11, 0, 0, q, e, lat);
        chk("sz11_ld", 32'(e), 32'd1);
        chk("sz11_dout", q, 32'd0);

        acc(0, 14'h2FFE, 2'b10, 0, 0, q, e, lat);
        chk("oor_w", 32'(e), 32'd1);
        acc(0, 14'h2FFF, 2'b01, 0, 0, q, e, lat);
        chk("oor_h", 32'(e), 32'd1);
        acc(1, 14'h2FFC, 2'b10, 0, 32'h8899AABB, q, e, lat);
        chk("top_err", 32'(e), 32'd0);
        acc(0, 14'h2FFF, 2'b00, 1, 0, q, e, lat);
        chk("top_lb", q, 32'hFFFFFF88);
        chk("top_lb_err", 32'(e), 32'd0);

        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 14'h10;
        bus.size = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        nb = 0;
        na = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) nb++;
            if (bus.ack) na++;
            @(negedge clk);
        end
        chk("busy_len", 32'(nb), 32'd5);
        chk("ack_cnt", 32'(na), 32'd1);

        ack1 = -1;
        ack2 = -1;
        bus.req = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 9) bus.req = 1'b0;
            if (bus.ack && ack1 < 0) ack1 = i;
            else if (bus.ack && ack2 < 0) ack2 = i;
        end
        chk("b2b_ack1", 32'(ack1), 32'd4);
        chk("b2b_ack2", 32'(ack2), 32'd9);
        chk("b2b_dout", bus.dout, 32'h11223344);

        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b1;
        bus.addr = 14'h10;
        bus.size = 2'b10;
        bus.din  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("wrst_ack", 32'(bus.ack), 32'd0);
        chk("wrst_busy", 32'(bus.busy), 32'd0);
        chk("wrst_dout", bus.dout, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc(0, 14'h10, 2'b10, 0, 0, q, e, lat);
        chk("wrst_mem", q, 32'h11223344);
        chk("wrst_lat", 32'(lat), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, fails);
        $finish;
    end

endmodule
